// File: rtl/sr_cmd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sr_cmd_seq : buffers set/reset/toggle commands and issues S/R pulses,        |
// | optionally checking Q afterwards (build macro SR_CHECK_EN).                  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module sr_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
`ifdef SR_CHECK_EN
    localparam logic [1:0] c_ST_CHECK = 2'd2;
    localparam logic [1:0] c_OP_SET   = 2'b01;
    localparam logic [1:0] c_OP_RST   = 2'b10;
    localparam logic [1:0] c_OP_TGL   = 2'b11;
`endif

    logic [1:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_s;
    logic        r_r;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_head;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_mem[r_rptr[AW-1:0]];
    assign cmd_ready = !w_full;
    assign s         = r_s;
    assign r         = r_r;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
`ifdef SR_CHECK_EN
            c_ST_ISSUE: w_state_nxt = c_ST_CHECK;
            c_ST_CHECK: begin
`else
            c_ST_ISSUE: begin
`endif
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_ISSUE;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef SR_CHECK_EN
        done = (r_state == c_ST_CHECK);
`else
        done = (r_state == c_ST_ISSUE);
`endif
        busy = !w_empty || (r_state != c_ST_IDLE);
    end

    // Op encoding puts "set" in bit 0 and "reset" in bit 1, so toggle drives both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s <= 1'b0;
            r_r <= 1'b0;
        end else begin
            r_s <= w_pop && w_head[0];
            r_r <= w_pop && w_head[1];
        end
    end

`ifdef SR_CHECK_EN
    logic [1:0]       r_op;
    logic             r_exp;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (w_pop) r_op <= w_head;
    end

    // Expected Q uses q_fb from the ISSUE cycle, before the SR stage updates.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_ISSUE) begin
            case (r_op)
                c_OP_SET: r_exp <= 1'b1;
                c_OP_RST: r_exp <= 1'b0;
                c_OP_TGL: r_exp <= ~q_fb;
                default:  r_exp <= q_fb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if ((r_state == c_ST_CHECK) && (q_fb != r_exp)) begin
            r_err <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign err     = r_err;
    assign err_cnt = r_cnt;
`else
    logic w_unused_q;
    assign w_unused_q = q_fb;
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sr_cmd_seq : scoreboard bench for sr_cmd_seq with an SR-stage model.      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_sr_cmd_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
`ifdef SR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic             cmd_ready;
    logic             s;
    logic             r;
    logic             q_fb;
    logic             done;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    sr_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .s(s), .r(r), .q_fb(q_fb), .done(done),
        .busy(busy), .err(err), .err_cnt(err_cnt)
    );

    // SR flip-flop stage downstream of the sequencer, with optional stuck-at-0 fault injection
    logic q_sr = 1'b0;
    bit   stuck = 1'b0;
    always @(posedge clk) q_sr <= (s & r) ? ~q_sr : s ? 1'b1 : r ? 1'b0 : q_sr;
    assign q_fb = stuck ? 1'b0 : q_sr;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: command queue plus one command in flight, one slot per PERIOD cycles
    int         cyc = 0;
    logic [1:0] mq[$];
    int         sb[$];
    int         next_free = 0;
    bit         inf_v = 0;
    logic [1:0] inf_op;
    int         inf_pop;
    bit         inf_exp;
    bit         m_err = 0;
    int         m_cnt = 0;
    bit         m_s = 0, m_r = 0, m_ready = 1, m_busy = 0, m_acc = 0;

    always @(posedge clk) begin
        int cnt_pre;
        logic [1:0] h;
        cyc++;
        cnt_pre = mq.size();
        m_s = 0;
        m_r = 0;
        m_acc = 0;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            inf_v = 0;
            next_free = 0;
            m_err = 0;
            m_cnt = 0;
        end else begin
            if (inf_v) begin
                if (CHK && cyc == inf_pop + 1)
                    inf_exp = (inf_op == OP_SET) ? 1'b1 : (inf_op == OP_RST) ? 1'b0 :
                              (inf_op == OP_TGL) ? ~q_fb : q_fb;
                if (cyc == inf_pop + (CHK ? 2 : 1)) begin
                    if (CHK && q_fb != inf_exp) begin
                        m_err = 1;
                        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    end
                    inf_v = 0;
                end
            end
            if (cnt_pre > 0 && cyc >= next_free) begin
                h = mq.pop_front();
                inf_v = 1;
                inf_op = h;
                inf_pop = cyc;
                next_free = cyc + (CHK ? 2 : 1);
                m_s = (h == OP_SET || h == OP_TGL);
                m_r = (h == OP_RST || h == OP_TGL);
                sb.push_back(cyc + (CHK ? 1 : 0));
            end
            if (cmd_valid && cnt_pre < DEPTH) begin
                mq.push_back(cmd_op);
                m_acc = 1;
            end
        end
        m_ready = (mq.size() < DEPTH);
        m_busy  = (mq.size() > 0) || (cyc < next_free);
    end

    // Monitor: per-cycle outputs against the model, done pulses against the scoreboard
    always @(negedge clk) begin
        int d;
        if (cyc > 0) begin
            chk("cmd_ready", cmd_ready, m_ready);
            chk("busy", busy, m_busy);
            chk("s", s, m_s);
            chk("r", r, m_r);
            chk("err", err, m_err);
            chk("err_cnt", err_cnt, m_cnt);
            while (sb.size() > 0 && sb[0] < cyc) begin
                d = sb.pop_front();
                chk("done_missing", 0, 1);
            end
            if (done) begin
                if (sb.size() == 0) chk("done_spurious", 1, 0);
                else begin
                    d = sb.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op);
        int tries = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        do begin
            @(negedge clk);
            tries++;
        end while (!m_acc && tries < 50);
        if (!m_acc) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        cmd_valid = 1'b0;
        while (m_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (m_busy) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send(OP_SET); send(OP_RST); send(OP_TGL);
        drain();

        for (int i = 0; i < 5; i++) send(2'($urandom_range(1, 3)));
        drain();

        for (int i = 0; i < 200; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        drain();

        stuck = 1'b1;
        for (int i = 0; i < 10; i++) send(OP_SET);
        send(OP_TGL); send(OP_HOLD);
        drain();
        stuck = 1'b0;

        // Reset lands during the ISSUE cycle of the first of three commands
        cmd_valid = 1'b1; cmd_op = OP_SET;
        @(negedge clk); cmd_op = OP_RST;
        @(negedge clk); cmd_op = OP_TGL; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; cmd_valid = 1'b0;
        repeat (6) @(negedge clk);

        send(OP_TGL); send(OP_HOLD); send(OP_SET); send(OP_SET);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
